cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control FSM that sequences the 16-bit RISC datapath: instruction fetch, decode, execute, data-memory access and register-file writeback. It drives the instruction-memory and data-memory request/acknowledge handshakes, owns the program counter and instruction register, and gates register-file write enables. It sits between the memories and the decoder/reg_file/ALU, replacing the free-running two-phase fetch toggle.

## Interface
- PC_W, 8, program-counter and memory address width
- HALT_OPCODE, 16'hFFFF, instruction word that halts the core
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- run  in  1  execution enable; sampled at instruction boundaries
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (equals pc while imem_req high)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  16  fetched instruction
- ir  out  16  latched instruction to decoder
- dec_is_branch  in  1  decoded instruction is a branch
- dec_is_ls  in  1  decoded instruction is load or store
- dec_is_store  in  1  decoded load/store is a store
- dec_we  in  1  decoded instruction writes a register
- br_taken  in  1  branch condition true (valid in EXECUTE)
- br_target  in  PC_W  branch destination (valid in EXECUTE)
- dmem_req  out  1  data-memory request
- dmem_we  out  1  data-memory write strobe (valid with dmem_req)
- dmem_ack  in  1  data access complete
- rf_we  out  1  register-file write enable
- pc  out  PC_W  program counter
- state  out  3  current FSM state (debug port)
- retired  out  8  retired-instruction counter (debug port)
- halted  out  1  core halted

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6. Encodings 7 unreachable; if entered, next state IDLE.
- IDLE: all requests low. run=1 -> FETCH.
- FETCH: imem_req=1, imem_addr=pc. Hold until imem_ack; on ack: ir<=imem_rdata, pc<=pc+1 (mod 2^PC_W), -> DECODE.
- DECODE: one cycle. ir==HALT_OPCODE -> HALT; else -> EXECUTE.
- EXECUTE: one cycle. dec_is_branch: pc<=br_target if br_taken, retire, -> boundary. dec_is_ls -> MEM. Otherwise -> WRITEBACK.
- MEM: dmem_req=1, dmem_we=dec_is_store. Hold until dmem_ack. Store: retire, -> boundary. Load -> WRITEBACK.
- WRITEBACK: rf_we=dec_we for exactly this cycle; retire; -> boundary.
- Boundary: run=1 -> FETCH, run=0 -> IDLE. run is ignored mid-instruction.
- HALT: halted=1, all requests low; sticky until reset. Not counted as retired.
- retired increments by 1 per retired instruction, wraps 255->0.
- Outputs imem_req, dmem_req, dmem_we, rf_we, halted are Moore (decoded from state only).
- Branch precedence over dec_is_ls if both asserted.

## Timing
- Reset (edge with reset=1): state=IDLE, pc=0, ir=0, retired=0; all outputs 0 from the following cycle. Reset during FETCH/MEM abandons the request; a late ack after reset is ignored.
- acks are sampled only while the matching req is high; acks while req is low are ignored.
- Requests stay high and address stable until ack; zero-wait memory (ack in first req cycle) legal.
- Minimum latency with zero-wait memory: ALU op 4 cycles (F,D,E,WB), branch 3, store 4, load 5. Each memory wait cycle adds 1.
- pc update on taken branch visible the cycle after EXECUTE; fetch of target starts that same cycle.

## Structure
- Shared package cpu_pkg: state enum (3-bit, values above), HALT_OPCODE constant, PC_W default.
- Single module; no sub-module. FSM next-state logic combinational, pc/ir/retired/state registered.

## Test plan
- Reset, run=1, zero-wait imem returning ALU op (dec_we=1) at pc 0 -> states 1,2,3,5; rf_we pulse at cycle 4; pc=1, retired=1.
- imem_ack delayed 3 cycles -> imem_req held 4 cycles, imem_addr constant, ir updates only on ack.
- Branch at pc=5, br_taken=1, br_target=8'h20 -> next imem_addr=8'h20; br_taken=0 -> 8'h06; rf_we never asserted.
- Load with dmem_ack after 2 cycles -> dmem_we=0, WRITEBACK follows; store -> dmem_we=1, no WRITEBACK, retired+1.
- Fetch 16'hFFFF -> HALT, halted=1, no further requests with run=1; reset returns to IDLE, pc=0. pc at 8'hFF wraps to 0.
- Drop run mid-MEM -> instruction completes, then IDLE; reset asserted during FETCH with pending ack -> IDLE, ir=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit RISC control path.
//   PC_W        default program-counter / memory address width
//   INSN_W      instruction word width
//   HALT_OPCODE instruction word that stops the core
//   state_e     sequencer state encoding (exported on the debug port)
package cpu_pkg;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned INSN_W = 16;
  localparam int unsigned RET_W  = 8;

  localparam logic [INSN_W-1:0] HALT_OPCODE = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_e;

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: instruction- and data-memory request/acknowledge handshakes.
//   master (sequencer): drives imem_req/imem_addr, dmem_req/dmem_we;
//                       receives imem_ack/imem_rdata, dmem_ack
//   slave  (memories):  the mirror image
// A request stays high with a stable address until its ack arrives.
interface cpu_sequencer_if #(
  parameter int unsigned PC_W = cpu_pkg::PC_W
);

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );

endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the 16-bit RISC datapath.
// Sequences fetch, decode, execute, data-memory access and writeback; owns
// the program counter and instruction register; gates register-file writes.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   run               execution enable, sampled only at instruction boundaries
//   mem               memory handshakes (cpu_sequencer_if.master)
//   ir                latched instruction to the decoder
//   dec_*             decoder flags for the instruction held in ir
//   br_taken/target   branch resolution, valid in EXECUTE
//   rf_we             register-file write enable (one WRITEBACK cycle)
//   pc, state,
//   retired, halted   program counter and debug/status outputs
module cpu_sequencer #(
  parameter int unsigned PC_W        = cpu_pkg::PC_W,
  parameter logic [15:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  cpu_sequencer_if.master     mem,
  output logic [15:0]         ir,
  input  logic                dec_is_branch,
  input  logic                dec_is_ls,
  input  logic                dec_is_store,
  input  logic                dec_we,
  input  logic                br_taken,
  input  logic [PC_W-1:0]     br_target,
  output logic                rf_we,
  output logic [PC_W-1:0]     pc,
  output logic [2:0]          state,
  output logic [7:0]          retired,
  output logic                halted
);

  import cpu_pkg::*;

  state_e             state_q, state_n;
  logic [PC_W-1:0]    pc_q, pc_n;
  logic [INSN_W-1:0]  ir_q, ir_n;
  logic [RET_W-1:0]   ret_q, ret_n;
  state_e             boundary;

  logic imem_req_q, dmem_req_q, dmem_we_q, rf_we_q, halted_q;

  // Where to go once an instruction has retired.
  assign boundary = run ? S_FETCH : S_IDLE;

  // Next-state, pc, ir and retire-counter logic.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    ir_n    = ir_q;
    ret_n   = ret_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_n = S_FETCH;
      end
      S_FETCH: begin
        if (mem.imem_ack) begin
          ir_n    = mem.imem_rdata;
          pc_n    = pc_q + PC_W'(1);
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        state_n = (ir_q == HALT_OPCODE) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        // Branch wins over load/store when the decoder flags both.
        if (dec_is_branch) begin
          if (br_taken) pc_n = br_target;
          ret_n   = ret_q + RET_W'(1);
          state_n = boundary;
        end else if (dec_is_ls) begin
          state_n = S_MEM;
        end else begin
          state_n = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (mem.dmem_ack) begin
          if (dec_is_store) begin
            ret_n   = ret_q + RET_W'(1);
            state_n = boundary;
          end else begin
            state_n = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        ret_n   = ret_q + RET_W'(1);
        state_n = boundary;
      end
      S_HALT: begin
        state_n = S_HALT;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Strobes are registered from the next
  // state, so each one is high exactly while the FSM sits in its state.
  // The decoder flags used for dmem_we/rf_we derive from ir, which is
  // already stable when those states are entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      ret_q      <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      ir_q       <= ir_n;
      ret_q      <= ret_n;
      imem_req_q <= (state_n == S_FETCH);
      dmem_req_q <= (state_n == S_MEM);
      dmem_we_q  <= (state_n == S_MEM) && dec_is_store;
      rf_we_q    <= (state_n == S_WRITEBACK) && dec_we;
      halted_q   <= (state_n == S_HALT);
    end
  end

  assign mem.imem_req  = imem_req_q;
  assign mem.imem_addr = pc_q;
  assign mem.dmem_req  = dmem_req_q;
  assign mem.dmem_we   = dmem_we_q;

  assign ir      = ir_q;
  assign rf_we   = rf_we_q;
  assign pc      = pc_q;
  assign state   = 3'(state_q);
  assign retired = ret_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer. A reference model
// walks a random instruction stream architecturally and queues the expected
// fetch / data-access / writeback events; a monitor pops and compares them as
// the DUT presents them. Memories answer with random wait states.
`timescale 1ns/1ps
module tb_cpu_sequencer;

  localparam int unsigned PC_W = 8;
  localparam int EV_FETCH = 0;
  localparam int EV_DMEM  = 1;
  localparam int EV_WB    = 2;
  localparam int K_ALU = 0;
  localparam int K_BR  = 1;
  localparam int K_LD  = 2;
  localparam int K_ST  = 3;

  typedef struct {
    int          kind;
    int          val;
    int          ret;
    int          gap;
    logic [15:0] word;
  } ev_t;

  logic clk = 1'b0;
  logic reset, run;
  logic dec_is_branch, dec_is_ls, dec_is_store, dec_we, br_taken;
  logic [PC_W-1:0] br_target, pc;
  logic [15:0] ir;
  logic rf_we, halted;
  logic [2:0] state;
  logic [7:0] retired;

  cpu_sequencer_if #(.PC_W(PC_W)) mif();

  cpu_sequencer #(.PC_W(PC_W), .HALT_OPCODE(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .run(run), .mem(mif), .ir(ir),
    .dec_is_branch(dec_is_branch), .dec_is_ls(dec_is_ls),
    .dec_is_store(dec_is_store), .dec_we(dec_we), .br_taken(br_taken),
    .br_target(br_target), .rf_we(rf_we), .pc(pc), .state(state),
    .retired(retired), .halted(halted)
  );

  always #5 clk = ~clk;

  // Toy decoder: [15]=load/store, [14]=store, [13]=writes reg,
  // [12]=branch taken, [11]=branch, [7:0]=branch target.
  always_comb begin
    dec_is_ls     = ir[15];
    dec_is_store  = ir[14];
    dec_we        = ir[13];
    br_taken      = ir[12];
    dec_is_branch = ir[11];
    br_target     = ir[7:0];
  end

  function automatic int kind_of(input logic [15:0] w);
    if (w[11]) return K_BR;
    if (w[15]) return w[14] ? K_ST : K_LD;
    return K_ALU;
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic flag(input string name, input int act);
    n_checks++;
    $display("FAIL %s: unexpected event, value %0d (t=%0t)", name, act, $time);
  endtask

  logic [15:0] words[$];
  int          iwait[$];
  int          dwait[$];
  ev_t         exp_q[$];

  // Reference model: architectural walk of the instruction stream.
  task automatic build(input int n, input bit timed, input bit wrap);
    int pc_m, ret_m, j, gap, base;
    logic [15:0] w;
    ev_t e;
    words.delete(); iwait.delete(); dwait.delete(); exp_q.delete();
    for (int k = 0; k < n; k++) begin
      w = 16'($urandom);
      if (w == 16'hFFFF) w = 16'h0000;
      words.push_back(w);
      iwait.push_back(int'($urandom_range(0, 3)));
      dwait.push_back(int'($urandom_range(0, 3)));
    end
    if (wrap) begin
      words[0] = 16'h18FE;           // taken branch to 8'hFE
      words[1] = words[1] & 16'h77FF; // two ALU ops: FE, FF, then wrap to 00
      words[2] = words[2] & 16'h77FF;
      words[3] = 16'h2000;           // zero-wait ALU op writing a register
      iwait[0] = 0; iwait[1] = 0; iwait[3] = 0; iwait[4] = 0;
    end
    words.push_back(16'hFFFF);
    iwait.push_back(0);
    pc_m = 0; ret_m = 0; j = 0; gap = -1; base = 0;
    for (int k = 0; k <= n; k++) begin
      w = words[k];
      e.kind = EV_FETCH; e.val = pc_m; e.ret = ret_m % 256;
      e.gap = timed ? gap : -1; e.word = w;
      exp_q.push_back(e);
      if (w == 16'hFFFF) break;
      pc_m = (pc_m + 1) % 256;
      e.gap = -1; e.ret = 0; e.word = 16'h0;
      case (kind_of(w))
        K_BR: begin
          if (w[12]) pc_m = int'(w[7:0]);
          base = 3;
        end
        K_ALU: begin
          e.kind = EV_WB; e.val = int'(w[13]); exp_q.push_back(e);
          base = 4;
        end
        K_ST: begin
          e.kind = EV_DMEM; e.val = 1; exp_q.push_back(e);
          base = 4 + dwait[j]; j++;
        end
        default: begin
          e.kind = EV_DMEM; e.val = 0; exp_q.push_back(e);
          e.kind = EV_WB;   e.val = int'(w[13]); exp_q.push_back(e);
          base = 5 + dwait[j]; j++;
        end
      endcase
      ret_m++;
      gap = base + iwait[k + 1];
    end
  endtask

  // Memory responders: random waits per request, random acks while idle.
  bit          manual = 1'b1;
  logic        m_iack = 1'b0, m_dack = 1'b0;
  logic [15:0] m_rdata = 16'h0;
  logic        a_iack = 1'b0, a_dack = 1'b0;
  logic [15:0] a_rdata = 16'h0;
  int fidx = 0, didx = 0, icnt = 0, dcnt = 0;
  bit ib = 1'b0, db = 1'b0;

  assign mif.imem_ack   = manual ? m_iack  : a_iack;
  assign mif.imem_rdata = manual ? m_rdata : a_rdata;
  assign mif.dmem_ack   = manual ? m_dack  : a_dack;

  always @(negedge clk) begin
    if (reset) begin
      fidx = 0; didx = 0; ib = 1'b0; db = 1'b0; a_iack = 1'b0; a_dack = 1'b0;
    end else begin
      if (mif.imem_req) begin
        if (!ib) begin ib = 1'b1; icnt = 0; end
        if (icnt >= ((fidx < iwait.size()) ? iwait[fidx] : 0)) begin
          a_iack  = 1'b1;
          a_rdata = (fidx < words.size()) ? words[fidx] : 16'h0000;
          fidx++; ib = 1'b0;
        end else begin
          a_iack = 1'b0; a_rdata = 16'($urandom); icnt++;
        end
      end else begin
        a_iack = 1'($urandom); a_rdata = 16'($urandom);
      end
      if (mif.dmem_req) begin
        if (!db) begin db = 1'b1; dcnt = 0; end
        if (dcnt >= ((didx < dwait.size()) ? dwait[didx] : 0)) begin
          a_dack = 1'b1; didx++; db = 1'b0;
        end else begin
          a_dack = 1'b0; dcnt++;
        end
      end else begin
        a_dack = 1'($urandom);
      end
    end
  end

  // Monitor: compares observed events against the scoreboard queue.
  bit          chk_en = 1'b0;
  int          cyc = 0, last_ack = 0;
  bit          ir_pend = 1'b0;
  logic [15:0] ir_exp = 16'h0, ir_prev = 16'h0;

  always @(negedge clk) begin
    ev_t e;
    #1;
    cyc++;
    if (reset) begin
      ir_pend = 1'b0; ir_prev = 16'h0;
    end else if (chk_en) begin
      if (ir_pend) begin
        check("ir_latch", int'(ir), int'(ir_exp));
        check("decode_after_fetch", int'(state), 2);
        ir_prev = ir_exp; ir_pend = 1'b0;
      end
      if (mif.imem_req) begin
        if (exp_q.size() == 0 || exp_q[0].kind != EV_FETCH) flag("unexpected_fetch", int'(mif.imem_addr));
        else begin
          check("fetch_addr", int'(mif.imem_addr), exp_q[0].val);
          if (mif.imem_ack) begin
            e = exp_q.pop_front();
            check("retired_at_fetch", int'(retired), e.ret);
            if (e.gap >= 0) check("fetch_gap", cyc - last_ack, e.gap);
            last_ack = cyc; ir_pend = 1'b1; ir_exp = e.word;
          end else begin
            check("ir_hold", int'(ir), int'(ir_prev));
          end
        end
      end
      if (mif.dmem_req) begin
        if (exp_q.size() == 0 || exp_q[0].kind != EV_DMEM) flag("unexpected_dmem", int'(mif.dmem_we));
        else begin
          check("dmem_we", int'(mif.dmem_we), exp_q[0].val);
          if (mif.dmem_ack) e = exp_q.pop_front();
        end
      end
      if (state == 3'd5) begin
        if (exp_q.size() == 0 || exp_q[0].kind != EV_WB) flag("unexpected_writeback", int'(rf_we));
        else begin
          e = exp_q.pop_front();
          check("rf_we", int'(rf_we), e.val);
        end
      end else if (rf_we) begin
        flag("rf_we_outside_writeback", int'(rf_we));
      end
      if (state == 3'd0) check("idle_quiet", int'({mif.imem_req, mif.dmem_req, rf_we}), 0);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_pc", int'(pc), 0);
    check("rst_ir", int'(ir), 0);
    check("rst_retired", int'(retired), 0);
    check("rst_halted", int'(halted), 0);
    reset = 1'b0;
  endtask

  task automatic run_seq(input int n, input bit timed, input bit wrap, input bit rand_run);
    int c;
    build(n, timed, wrap);
    manual = 1'b0; chk_en = 1'b1; run = 1'b1;
    c = 0;
    while (!halted && c < 20000) begin
      @(negedge clk);
      if (rand_run) run = ($urandom_range(0, 3) != 0);
      c++;
    end
    if (!halted) flag("halt_timeout", c);
    run = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("halt_no_imem_req", int'(mif.imem_req), 0);
      check("halt_no_dmem_req", int'(mif.dmem_req), 0);
      check("halt_state", int'(state), 6);
      check("halted", int'(halted), 1);
    end
    check("halt_retired", int'(retired), n % 256);
    check("scoreboard_drained", exp_q.size(), 0);
    chk_en = 1'b0;
  endtask

  task automatic wait_state(input int s, input int lim, input string name);
    int c = 0;
    while (int'(state) != s && c < lim) begin @(negedge clk); c++; end
    check(name, int'(state), s);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0;
    repeat (3) @(negedge clk);
    check("init_state", int'(state), 0);
    check("init_pc", int'(pc), 0);
    check("init_ir", int'(ir), 0);
    check("init_retired", int'(retired), 0);
    check("init_halted", int'(halted), 0);
    check("init_reqs", int'({mif.imem_req, mif.dmem_req, rf_we}), 0);
    reset = 1'b0;

    run_seq(40, 1'b1, 1'b1, 1'b0);   // run held high: exact latencies, pc wrap
    do_reset();
    run_seq(60, 1'b0, 1'b0, 1'b1);   // run toggled at random
    do_reset();

    // Reset while a fetch is outstanding and its ack arrives.
    manual = 1'b1; m_iack = 1'b0; m_dack = 1'b0; run = 1'b1;
    wait_state(1, 5, "enter_fetch");
    @(negedge clk);
    check("fetch_held", int'(mif.imem_req), 1);
    m_iack = 1'b1; m_rdata = 16'h1234; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; run = 1'b0;         // ack stays high: late ack
    check("rst_fetch_state", int'(state), 0);
    check("rst_fetch_ir", int'(ir), 0);
    check("rst_fetch_req", int'(mif.imem_req), 0);
    @(negedge clk);
    check("late_ack_ignored_state", int'(state), 0);
    check("late_ack_ignored_ir", int'(ir), 0);

    // Load that sees run dropped while waiting in MEM.
    m_rdata = 16'hA000; run = 1'b1;
    wait_state(4, 10, "reach_mem");
    m_iack = 1'b0; run = 1'b0;
    repeat (2) @(negedge clk);
    check("mem_hold_state", int'(state), 4);
    check("mem_hold_req", int'(mif.dmem_req), 1);
    check("load_dmem_we", int'(mif.dmem_we), 0);
    m_dack = 1'b1;
    @(negedge clk);
    m_dack = 1'b0;
    check("load_writeback", int'(state), 5);
    check("load_rf_we", int'(rf_we), 1);
    @(negedge clk);
    check("run_low_to_idle", int'(state), 0);
    check("load_retired", int'(retired), 1);
    check("load_pc", int'(pc), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
